// File: rtl/if_stage.sv
// Instruction-fetch stage of the RV32I pipeline.
// Owns the PC and the IF/ID register, and handles redirect/squash, stall, EBREAK halt and misaligned-target faults.
module if_stage #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR      = 32'h0000_0013,
   parameter bit          HALT_ON_EBREAK = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   output logic [31:0] pc_out,
   input  logic [31:0] instr_if,
   input  logic        stall,
   input  logic        redirect_en,
   input  logic [31:0] redirect_pc,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic [31:0] if_id_instr,
   output logic        if_id_valid,
   output logic        halted,
   output logic        fetch_fault
);

   localparam logic [31:0] EBREAK = 32'h0010_0073;

   typedef enum logic [1:0] {RUN, HALT_PEND, HALT, FAULT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] if_id_pc_q, if_id_pc_d;
   logic [31:0] if_id_pc4_q, if_id_pc4_d;
   logic [31:0] if_id_instr_q, if_id_instr_d;
   logic        if_id_valid_q, if_id_valid_d;
   logic        halted_q, halted_d;
   logic        fault_q, fault_d;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_pc4_d   = if_id_pc4_q;
      if_id_instr_d = if_id_instr_q;
      if_id_valid_d = if_id_valid_q;
      halted_d      = halted_q;
      fault_d       = fault_q;

      case (state_q)
         RUN, HALT_PEND: begin
            if (redirect_en) begin
               // A redirect squashes whatever is in ID, including a pending EBREAK.
               pc_d          = redirect_pc;
               if_id_pc_d    = 32'd0;
               if_id_pc4_d   = 32'd4;
               if_id_instr_d = NOP_INSTR;
               if_id_valid_d = 1'b0;
               if (redirect_pc[1:0] != 2'b00) begin
                  state_d = FAULT;
                  fault_d = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end else if (!stall) begin
               if (state_q == RUN) begin
                  pc_d          = pc_plus4;
                  if_id_pc_d    = pc_q;
                  if_id_pc4_d   = pc_plus4;
                  if_id_instr_d = instr_if;
                  if_id_valid_d = 1'b1;
                  if (HALT_ON_EBREAK && instr_if == EBREAK)
                     state_d = HALT_PEND;
               end else begin
                  if_id_pc_d    = 32'd0;
                  if_id_pc4_d   = 32'd4;
                  if_id_instr_d = NOP_INSTR;
                  if_id_valid_d = 1'b0;
                  state_d       = HALT;
                  halted_d      = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= RUN;
         pc_q          <= RESET_PC;
         if_id_pc_q    <= 32'd0;
         if_id_pc4_q   <= 32'd4;
         if_id_instr_q <= NOP_INSTR;
         if_id_valid_q <= 1'b0;
         halted_q      <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_pc4_q   <= if_id_pc4_d;
         if_id_instr_q <= if_id_instr_d;
         if_id_valid_q <= if_id_valid_d;
         halted_q      <= halted_d;
         fault_q       <= fault_d;
      end
   end

   assign pc_out         = pc_q;
   assign if_id_pc       = if_id_pc_q;
   assign if_id_pc_plus4 = if_id_pc4_q;
   assign if_id_instr    = if_id_instr_q;
   assign if_id_valid    = if_id_valid_q;
   assign halted         = halted_q;
   assign fetch_fault    = fault_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline.
- Owns the program counter and drives the combinational instruction memory address.
- Captures the returned word into the IF/ID pipeline register.
- Handles stall, branch/jump redirect with squash, EBREAK halt, and misaligned-target fault; sits between instr_mem and the decode stage inside cpu.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0) placed in IF/ID when squashing.
- HALT_ON_EBREAK, 1, when 1 an EBREAK (32'h00100073) reaching ID stops fetch permanently.

Ports:
- clk  input  1  pipeline clock, rising edge
- resetn  input  1  asynchronous active-low reset
- pc_out  output  32  fetch address to instr_mem
- instr_if  input  32  instruction word from instr_mem, combinational on pc_out
- stall  input  1  hazard unit: hold PC and IF/ID
- redirect_en  input  1  EX stage: taken branch/jump this cycle
- redirect_pc  input  32  target address, valid when redirect_en=1
- if_id_pc  output  32  PC of instruction in ID
- if_id_pc_plus4  output  32  if_id_pc+4, for JAL/JALR link
- if_id_instr  output  32  instruction in ID
- if_id_valid  output  1  1 = real instruction, 0 = bubble
- halted  output  1  fetch stopped by EBREAK
- fetch_fault  output  1  fetch stopped by misaligned redirect

Behaviour:
- Reset (asynchronous, any state): pc_out=RESET_PC, if_id_pc=0, if_id_pc_plus4=4, if_id_instr=NOP_INSTR, if_id_valid=0, halted=0, fetch_fault=0, state=RUN. Reset asserted mid-program discards all in-flight state; the first fetch after release is RESET_PC.
- Latency: instr_if is sampled in the same cycle pc_out is presented; it appears on if_id_* after the next rising edge (1 cycle).
- FSM states: RUN, HALT_PEND, HALT, FAULT.
- RUN, priority redirect > stall > normal:
  - redirect_en=1 with redirect_pc[1:0]==0: pc<=redirect_pc; IF/ID<=bubble (NOP_INSTR, valid=0, pc fields 0/4). Applies even when stall=1.
  - redirect_en=1 with redirect_pc[1:0]!=0: pc<=redirect_pc; IF/ID<=bubble; go to FAULT.
  - stall=1: pc and IF/ID hold.
  - Otherwise: IF/ID<={pc_out, pc_out+4, instr_if, valid=1}; pc<=pc_out+4 (32-bit wrap, FFFFFFFC->00000000).
  - If the word latched is EBREAK and HALT_ON_EBREAK=1, go to HALT_PEND.
- HALT_PEND (EBREAK held in ID; an older branch in EX may still squash it): pc holds.
  - redirect_en: handled exactly as in RUN, next state RUN or FAULT.
  - stall: hold everything.
  - Otherwise: IF/ID<=bubble; go to HALT.
- HALT: halted=1; pc holds; IF/ID holds bubble; redirect_en and stall are ignored. Exit only by reset.
- FAULT: fetch_fault=1; pc_out holds the faulting address; IF/ID bubble; all inputs ignored. Exit only by reset.
- halted and fetch_fault are registered and never both 1.
- if_id_pc_plus4 always equals if_id_pc+4 except for the reset/bubble value of 4.

Test Plan:
- Reset then 4 free-running cycles, imem holding 0x00500513 at address 0 -> pc_out 0,4,8,C; one cycle after reset release if_id_instr=00500513, if_id_pc=0, if_id_valid=1.
- stall=1 for 3 cycles at pc_out=8 -> pc_out and if_id_* unchanged for 3 cycles; fetch resumes at 8 then C.
- redirect_en=1 with redirect_pc=0x40 and stall=1 in the same cycle -> next cycle pc_out=0x40, if_id_valid=0, if_id_instr=00000013; the following cycle if_id_pc=0x40.
- EBREAK at 0x10 with no redirect -> HALT_PEND for 1 cycle, then halted=1 with pc_out frozen at 0x14. Repeat with redirect_en=1, redirect_pc=0x80 during HALT_PEND -> halted stays 0 and fetch continues from 0x80.
- redirect_pc=0x22 -> fetch_fault=1 next cycle; pc_out=0x22 held; if_id_valid=0 for 20 cycles despite later redirects.
- resetn pulsed low for 3 ns at pc_out=0x30 (asynchronous, not clock-aligned) -> outputs return to reset values immediately; fetch restarts at RESET_PC; halted and fetch_fault are cleared.
